// File: rtl/hex_display_scroller.sv
// -----------------------------------------------------------------------------
// hex_display_scroller
//
// Drives a bank of seven-segment digits from one captured data word. The word,
// the zero flag and the display mode are captured into shadow registers on
// load, so the display stays stable between loads. The segment outputs are
// registered and recomputed every cycle from the shadow state and the current
// scroll offset. There is no combinational path from any input to any output.
//
// Modes (shadow modo):
//   00  hex, static        digit d shows nibble d, optional leading-zero blank
//   01  hex, scrolling     digit d shows nibble pos+d, pos steps on each tick
//   10  raw                one data bit per segment, zero flag after the data
//   11  blank              all digits off
//
// Ports:
//   clk      rising-edge system clock
//   reset    synchronous, active-high; overrides load
//   load     capture entrada/zero/modo into the shadow registers this edge
//   entrada  word to display (DATA_W bits)
//   zero     ALU zero flag, shown in raw mode
//   modo     display mode, see above
//   saida    segments, digit d = saida[7d+6:7d], bit s = segment s
//            (0 top, 1 upper-right, 2 lower-right, 3 bottom,
//             4 lower-left, 5 upper-left, 6 middle)
//   pos_o    current scroll offset in nibbles (debug)
// -----------------------------------------------------------------------------
module hex_display_scroller #(
   parameter  int DATA_W     = 32,
   parameter  int N_DIGITS   = 8,
   parameter  int SCROLL_DIV = 25_000_000,
   parameter  int LZ_BLANK   = 1,
   parameter  int ACTIVE_LOW = 1,
   localparam int NIB        = (DATA_W + 3) / 4,
   localparam int POS_W      = $clog2(NIB + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [DATA_W-1:0]       entrada,
   input  logic                    zero,
   input  logic [1:0]              modo,
   output logic [7*N_DIGITS-1:0]   saida,
   output logic [POS_W-1:0]        pos_o
);

   typedef enum logic [1:0] {
      MODE_HEX    = 2'b00,
      MODE_SCROLL = 2'b01,
      MODE_RAW    = 2'b10,
      MODE_BLANK  = 2'b11
   } mode_t;

   localparam int SEG_W     = 7 * N_DIGITS;
   // Nibble vector wide enough for both the word and every digit position.
   localparam int WIN       = (NIB > N_DIGITS) ? NIB : N_DIGITS;
   // Raw source: data bits, then the zero flag, padded to cover every segment.
   localparam int RAW_W     = (DATA_W + 1 > SEG_W) ? DATA_W + 1 : SEG_W;
   localparam bit SCROLL_EN = (NIB > N_DIGITS);
   localparam int MAX_POS   = SCROLL_EN ? NIB - N_DIGITS : 0;
   localparam int DIV_W     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [SEG_W-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;

   // Active-high hex font.
   function automatic logic [6:0] hex_font(input logic [3:0] n);
      logic [6:0] f;
      case (n)
         4'h0:    f = 7'h3F;
         4'h1:    f = 7'h06;
         4'h2:    f = 7'h5B;
         4'h3:    f = 7'h4F;
         4'h4:    f = 7'h66;
         4'h5:    f = 7'h6D;
         4'h6:    f = 7'h7D;
         4'h7:    f = 7'h07;
         4'h8:    f = 7'h7F;
         4'h9:    f = 7'h6F;
         4'hA:    f = 7'h77;
         4'hB:    f = 7'h7C;
         4'hC:    f = 7'h39;
         4'hD:    f = 7'h5E;
         4'hE:    f = 7'h79;
         default: f = 7'h71;
      endcase
      return f;
   endfunction

   // Raw mode walks the segments of a digit in the order 5,0,1,2,3,4,6.
   function automatic int raw_slot_seg(input int slot);
      int s;
      case (slot)
         0:       s = 5;
         1:       s = 0;
         2:       s = 1;
         3:       s = 2;
         4:       s = 3;
         5:       s = 4;
         default: s = 6;
      endcase
      return s;
   endfunction

   // Shadow state
   logic [DATA_W-1:0] data_q;
   logic              zero_q;
   mode_t             modo_q;
   logic [POS_W-1:0]  pos_q;
   logic [DIV_W-1:0]  div_q;
   logic              tick;

   assign tick  = (div_q == DIV_W'(SCROLL_DIV - 1));
   assign pos_o = pos_q;

   // Next segment image
   logic [4*WIN-1:0] nib_vec;
   logic [4*WIN-1:0] win_vec;
   logic [RAW_W-1:0] raw_vec;
   int               top_nz;
   logic [SEG_W-1:0] lit;
   logic [SEG_W-1:0] seg_next;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      nib_vec               = '0;
      nib_vec[DATA_W-1:0]   = data_q;
      win_vec               = nib_vec >> {pos_q, 2'b00};
      raw_vec               = '0;
      raw_vec[DATA_W:0]     = {zero_q, data_q};
      lit                   = '0;

      // Index of the most-significant nonzero nibble (0 when the word is 0).
      top_nz = 0;
      for (int i = 0; i < NIB; i++) begin
         if (nib_vec[4*i +: 4] != 4'h0) top_nz = i;
      end

      case (modo_q)
         MODE_HEX: begin
            for (int d = 0; d < N_DIGITS; d++) begin
               if (d < NIB && (LZ_BLANK == 0 || d == 0 || d <= top_nz))
                  lit[7*d +: 7] = hex_font(nib_vec[4*d +: 4]);
            end
         end
         MODE_SCROLL: begin
            // A word that already fits shows statically, without blanking.
            for (int d = 0; d < N_DIGITS; d++) begin
               if (SCROLL_EN)
                  lit[7*d +: 7] = hex_font(win_vec[4*d +: 4]);
               else if (d < NIB)
                  lit[7*d +: 7] = hex_font(nib_vec[4*d +: 4]);
            end
         end
         MODE_RAW: begin
            // Slots past the zero flag read padding zeros; bits beyond the
            // last digit never reach a segment.
            for (int k = 0; k < SEG_W; k++)
               lit[7*(k/7) + raw_slot_seg(k%7)] = raw_vec[k];
         end
         default: ;
      endcase

      seg_next = (ACTIVE_LOW != 0) ? ~lit : lit;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         zero_q <= 1'b0;
         modo_q <= MODE_BLANK;
         pos_q  <= '0;
         div_q  <= '0;
         saida  <= SEG_OFF;
      end else begin
         saida <= seg_next;
         div_q <= tick ? '0 : div_q + DIV_W'(1);

         if (load) begin
            // Load beats a coincident tick: offset and divider both restart.
            data_q <= entrada;
            zero_q <= zero;
            modo_q <= mode_t'(modo);
            pos_q  <= '0;
            div_q  <= '0;
         end else if (SCROLL_EN && modo_q == MODE_SCROLL) begin
            if (tick)
               pos_q <= (pos_q == POS_W'(MAX_POS)) ? '0 : pos_q + POS_W'(1);
         end else begin
            pos_q <= '0;
         end
      end
   end

endmodule
